// File: rtl/i2c_pkg.sv
// Shared I2C definitions used by i2c_master and i2c_target: master command
// codes, target FSM state encoding and bus ACK/NACK levels.
package i2c_pkg;

  typedef enum logic [2:0] {
    CMD_NOP, CMD_START, CMD_WRITE, CMD_READ, CMD_STOP, CMD_RSTART
  } i2c_cmd_e;

  typedef enum logic [2:0] {
    TGT_IDLE, TGT_ADDR, TGT_ADDR_ACK, TGT_WR_DATA,
    TGT_WR_ACK, TGT_RD_DATA, TGT_RD_ACK, TGT_IGNORE
  } tgt_state_e;

  localparam logic       ACK_LVL      = 1'b0;
  localparam logic       NACK_LVL     = 1'b1;
  localparam logic [6:0] GENERAL_CALL = 7'h00;

endpackage

// File: rtl/i2c_in_filter.sv
// Pad input conditioner: 2-FF synchronizer, then a glitch filter that only
// accepts a new level after it has been stable for FLT_LEN clocks. Rise/fall
// pulses coincide with the filtered level update (pad -> edge = 2+FLT_LEN clk).
module i2c_in_filter #(
  parameter int FLT_LEN = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pad,
  output logic lvl,
  output logic rise,
  output logic fall
);
  localparam int CW = $clog2(FLT_LEN + 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt;
  logic          flip;

  assign flip = (sync_q[1] != lvl) && (cnt == CW'(FLT_LEN - 1));

  // Synchronize the asynchronous pad; idle bus level is high.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], pad};
  end

  // Count consecutive cycles the synchronized level differs from the filtered one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl  <= 1'b1;
      cnt  <= '0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= flip &  sync_q[1];
      fall <= flip & ~sync_q[1];
      if (sync_q[1] == lvl) begin
        cnt <= '0;
      end else if (flip) begin
        lvl <= sync_q[1];
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_target.sv
// I2C target: answers one 7-bit address, reports write bytes on rx_*, fetches
// read bytes through tx_req/tx_valid. Lines are open-drain (*_oe = pull low).
// Optional clock stretching on late read data: define I2C_TARGET_STRETCH_EN.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] ADDR    = 7'h3C,
  parameter int         FLT_LEN = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       scl_oe,
  output logic       sda_oe,
  output logic       evt_start,
  output logic       evt_stop,
  output logic [7:0] rx_data,
  output logic       rx_stb,
  output logic       tx_req,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_nack,
  output logic       busy
);
  logic scl_lvl, scl_rise, scl_fall, sda_lvl, sda_rise, sda_fall;
  logic start_c, stop_c, start_byte;

  tgt_state_e state, state_d;
  logic [3:0] bit_cnt, cnt_d;
  logic [7:0] shreg, sh_d, tx_buf, tx_buf_d, rx_data_d;
  logic rw, rw_d, tx_open, tx_open_d, tx_have, tx_have_d, rd_first, rd_first_d;
  logic sda_oe_d, busy_d, evt_start_d, evt_stop_d, rx_stb_d, tx_req_d, tx_nack_d;

  i2c_in_filter #(.FLT_LEN(FLT_LEN)) u_scl_flt (
    .clk(clk), .rst_n(rst_n), .pad(scl_i), .lvl(scl_lvl), .rise(scl_rise), .fall(scl_fall));
  i2c_in_filter #(.FLT_LEN(FLT_LEN)) u_sda_flt (
    .clk(clk), .rst_n(rst_n), .pad(sda_i), .lvl(sda_lvl), .rise(sda_rise), .fall(sda_fall));

  // Bus conditions take priority over any bit sample in the same cycle.
  assign start_c = sda_fall & scl_lvl;
  assign stop_c  = sda_rise & scl_lvl;

`ifdef I2C_TARGET_STRETCH_EN
  logic scl_hold, scl_hold_d;
  assign scl_oe = scl_hold;
`else
  assign scl_oe = 1'b0;
`endif

  // Next-state, datapath and pulse computation.
  // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d     = state;
    cnt_d       = bit_cnt;
    sh_d        = shreg;
    rw_d        = rw;
    tx_buf_d    = tx_buf;
    tx_open_d   = tx_open;
    tx_have_d   = tx_have;
    rd_first_d  = rd_first;
    sda_oe_d    = sda_oe;
    busy_d      = busy;
    rx_data_d   = rx_data;
    evt_start_d = 1'b0;
    evt_stop_d  = 1'b0;
    rx_stb_d    = 1'b0;
    tx_req_d    = 1'b0;
    tx_nack_d   = 1'b0;
    start_byte  = 1'b0;
`ifdef I2C_TARGET_STRETCH_EN
    scl_hold_d  = scl_hold;
`endif

    // Read byte capture window: open from tx_req until the byte starts.
    if (tx_valid && tx_open) begin
      tx_buf_d  = tx_data;
      tx_have_d = 1'b1;
    end

    if (start_c || stop_c) begin
      state_d     = start_c ? TGT_ADDR : TGT_IDLE;
      evt_start_d = start_c;
      evt_stop_d  = stop_c;
      cnt_d       = '0;
      sda_oe_d    = 1'b0;
      busy_d      = 1'b0;
      tx_open_d   = 1'b0;
      tx_have_d   = 1'b0;
      rd_first_d  = 1'b0;
`ifdef I2C_TARGET_STRETCH_EN
      scl_hold_d  = 1'b0;
`endif
    end else begin
      case (state)
        TGT_ADDR: if (scl_rise) begin
          sh_d  = {shreg[6:0], sda_lvl};
          cnt_d = bit_cnt + 4'd1;
          if (bit_cnt == 4'd7) begin
            cnt_d = '0;
            if (sh_d[7:1] == ADDR && sh_d[7:1] != GENERAL_CALL) begin
              state_d = TGT_ADDR_ACK;
              busy_d  = 1'b1;
              rw_d    = sh_d[0];
              if (sh_d[0]) begin
                tx_req_d  = 1'b1;
                tx_open_d = 1'b1;
                tx_have_d = 1'b0;
              end
            end else begin
              state_d = TGT_IGNORE;
            end
          end
        end
        // bit_cnt 0: waiting for the fall that opens the ACK slot; 1: inside it.
        TGT_ADDR_ACK, TGT_WR_ACK: if (scl_fall) begin
          if (bit_cnt == 4'd0) begin
            sda_oe_d = ~ACK_LVL;
            cnt_d    = 4'd1;
          end else begin
            sda_oe_d = 1'b0;
            cnt_d    = '0;
            if (state == TGT_ADDR_ACK && rw) begin
              state_d    = TGT_RD_DATA;
              start_byte = 1'b1;
            end else begin
              state_d = TGT_WR_DATA;
            end
          end
        end
        TGT_WR_DATA: if (scl_rise) begin
          sh_d  = {shreg[6:0], sda_lvl};
          cnt_d = bit_cnt + 4'd1;
          if (bit_cnt == 4'd7) begin
            rx_data_d = sh_d;
            rx_stb_d  = 1'b1;
            state_d   = TGT_WR_ACK;
            cnt_d     = '0;
          end
        end
        TGT_RD_DATA: begin
          if (scl_fall) begin
            if (rd_first) begin
              start_byte = 1'b1;
            end else if (bit_cnt == 4'd8) begin
              state_d  = TGT_RD_ACK;
              sda_oe_d = 1'b0;
              cnt_d    = '0;
            end else begin
              sh_d     = {shreg[6:0], 1'b1};
              sda_oe_d = ~shreg[6];
            end
          end else if (scl_rise && !rd_first) begin
            cnt_d = bit_cnt + 4'd1;
          end
        end
        TGT_RD_ACK: if (scl_rise) begin
          if (sda_lvl == ACK_LVL) begin
            tx_req_d   = 1'b1;
            tx_open_d  = 1'b1;
            tx_have_d  = 1'b0;
            rd_first_d = 1'b1;
            state_d    = TGT_RD_DATA;
          end else begin
            tx_nack_d = 1'b1;
            state_d   = TGT_IGNORE;
          end
        end
        default: ;
      endcase

      // First fall of a read byte: present the MSB, or fall back when no data.
      if (start_byte) begin
        cnt_d      = '0;
        rd_first_d = 1'b0;
        if (tx_have_d) begin
          sh_d      = tx_buf_d;
          sda_oe_d  = ~tx_buf_d[7];
          tx_open_d = 1'b0;
          tx_have_d = 1'b0;
        end else begin
`ifdef I2C_TARGET_STRETCH_EN
          scl_hold_d = 1'b1;
          sda_oe_d   = 1'b0;
`else
          sh_d      = 8'hFF;
          sda_oe_d  = 1'b0;
          tx_open_d = 1'b0;
`endif
        end
      end

`ifdef I2C_TARGET_STRETCH_EN
      // Data arrived during a stretch: release SCL together with the MSB.
      if (scl_hold && tx_have) begin
        scl_hold_d = 1'b0;
        sh_d       = tx_buf;
        sda_oe_d   = ~tx_buf[7];
        tx_open_d  = 1'b0;
        tx_have_d  = 1'b0;
      end
`endif
    end
  end

  // State and datapath registers; reset releases both lines immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= TGT_IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      rw        <= 1'b0;
      tx_buf    <= '0;
      tx_open   <= 1'b0;
      tx_have   <= 1'b0;
      rd_first  <= 1'b0;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      rx_data   <= 8'h00;
      evt_start <= 1'b0;
      evt_stop  <= 1'b0;
      rx_stb    <= 1'b0;
      tx_req    <= 1'b0;
      tx_nack   <= 1'b0;
`ifdef I2C_TARGET_STRETCH_EN
      scl_hold  <= 1'b0;
`endif
    end else begin
      state     <= state_d;
      bit_cnt   <= cnt_d;
      shreg     <= sh_d;
      rw        <= rw_d;
      tx_buf    <= tx_buf_d;
      tx_open   <= tx_open_d;
      tx_have   <= tx_have_d;
      rd_first  <= rd_first_d;
      sda_oe    <= sda_oe_d;
      busy      <= busy_d;
      rx_data   <= rx_data_d;
      evt_start <= evt_start_d;
      evt_stop  <= evt_stop_d;
      rx_stb    <= rx_stb_d;
      tx_req    <= tx_req_d;
      tx_nack   <= tx_nack_d;
`ifdef I2C_TARGET_STRETCH_EN
      scl_hold  <= scl_hold_d;
`endif
    end
  end

endmodule
